// File: rtl/toy_pkg.sv
// ---------------------------------------------------------------------------
// toy_pkg
// Shared types and default sizes for the toy accumulate-kernel datapath.
//   ld_state_t  : load-unit state (LD_IDLE, LD_REQ, LD_DONE), 2-bit encoding
//   TOY_DATA_W  : default memory data / accumulator / result width
//   TOY_TRIP_W  : default trip count / induction variable / address width
// ---------------------------------------------------------------------------
package toy_pkg;

    localparam int TOY_DATA_W = 32;
    localparam int TOY_TRIP_W = 8;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_REQ  = 2'd1,
        LD_DONE = 2'd2
    } ld_state_t;

endpackage

// File: rtl/toy_load_unit.sv
// ---------------------------------------------------------------------------
// toy_load_unit
// Handles the STATE_1 load: issues one memory request, captures the returned
// word and stalls the controller until the word is available.
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   load_state      : controller is in STATE_1
//   mem_ack         : memory accept/return (rdata valid in the same cycle)
//   mem_rdata       : memory read data
//   mem_req         : registered load request
//   ld_data         : last captured load word
//   fsm_stall       : combinational stall back to the controller
// ---------------------------------------------------------------------------
module toy_load_unit
    import toy_pkg::*;
#(
    parameter int DATA_W = TOY_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_state,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic [DATA_W-1:0] ld_data,
    output logic              fsm_stall
);

    ld_state_t         ld_state_reg;
    logic              mem_req_reg;
    logic [DATA_W-1:0] ld_data_reg;

    // The controller may only leave STATE_1 once the word has been captured.
    assign fsm_stall = load_state && (ld_state_reg != LD_DONE);
    assign mem_req   = mem_req_reg;
    assign ld_data   = ld_data_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ld_state_reg <= LD_IDLE;
            mem_req_reg  <= 1'b0;
            ld_data_reg  <= '0;
        end else begin
            case (ld_state_reg)
                LD_IDLE: begin
                    if (load_state) begin
                        ld_state_reg <= LD_REQ;
                        mem_req_reg  <= 1'b1;
                    end
                end
                LD_REQ: begin
                    // Request and address stay steady until the memory accepts.
                    if (mem_ack) begin
                        ld_data_reg  <= mem_rdata;
                        mem_req_reg  <= 1'b0;
                        ld_state_reg <= LD_DONE;
                    end
                end
                LD_DONE: begin
                    if (load_state && !fsm_stall) begin
                        ld_state_reg <= LD_IDLE;
                    end
                end
                default: begin
                    ld_state_reg <= LD_IDLE;
                    mem_req_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/toy_loop_datapath.sv
// ---------------------------------------------------------------------------
// toy_loop_datapath
// Loop datapath for the toy accumulate kernel, driven by the one-hot
// controller. Each iteration loads one word (STATE_1), adds it to a wrapping
// accumulator (STATE_2) and advances the induction variable (STATE_3); the sum
// is published in STATE_4.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   start, trip_count   : host start and iteration count (sampled in STATE_0)
//   is_STATE_0..4       : one-hot controller state
//   fsm_stall, BB_1_EXIT: combinational feedback to the controller
//   mem_req, mem_addr, mem_ack, mem_rdata : load memory port
//   result, result_valid: final sum and its one-cycle update pulse
//   acc_overflow        : sticky carry-out flag, present only when
//                         TOY_DP_OVERFLOW_EN is defined
// ---------------------------------------------------------------------------
module toy_loop_datapath
    import toy_pkg::*;
#(
    parameter int DATA_W = TOY_DATA_W,
    parameter int TRIP_W = TOY_TRIP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [TRIP_W-1:0] trip_count,
    input  logic              is_STATE_0,
    input  logic              is_STATE_1,
    input  logic              is_STATE_2,
    input  logic              is_STATE_3,
    input  logic              is_STATE_4,
    output logic              fsm_stall,
    output logic              BB_1_EXIT,
    output logic              mem_req,
    output logic [TRIP_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] result,
    output logic              result_valid
`ifdef TOY_DP_OVERFLOW_EN
    ,
    output logic              acc_overflow
`endif
);

    logic [TRIP_W-1:0] i_reg;
    logic [TRIP_W-1:0] limit_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] result_reg;
    logic              result_valid_reg;
    logic [DATA_W-1:0] ld_data;
    logic [TRIP_W-1:0] limit_next;

    toy_load_unit #(
        .DATA_W (DATA_W)
    ) u_load (
        .clk        (clk),
        .reset      (reset),
        .load_state (is_STATE_1),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_req    (mem_req),
        .ld_data    (ld_data),
        .fsm_stall  (fsm_stall)
    );

    // Do-while loop: a trip count of zero still runs one iteration.
    assign limit_next = (trip_count == '0) ? TRIP_W'(1) : trip_count;

    // Compared one bit wider so i=2^TRIP_W-1 cannot wrap into a false match.
    assign BB_1_EXIT = is_STATE_3 &&
                       (({1'b0, i_reg} + (TRIP_W+1)'(1)) == {1'b0, limit_reg});

    assign mem_addr     = i_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;

`ifdef TOY_DP_OVERFLOW_EN
    logic [DATA_W:0] sum_wide;
    logic            acc_overflow_reg;

    assign sum_wide     = {1'b0, acc_reg} + {1'b0, ld_data};
    assign acc_overflow = acc_overflow_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_overflow_reg <= 1'b0;
        end else if (!fsm_stall) begin
            if (is_STATE_0 && start) begin
                acc_overflow_reg <= 1'b0;
            end else if (is_STATE_2 && sum_wide[DATA_W]) begin
                acc_overflow_reg <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            i_reg            <= '0;
            limit_reg        <= TRIP_W'(1);
            acc_reg          <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            if (!fsm_stall) begin
                if (is_STATE_0 && start) begin
                    limit_reg <= limit_next;
                    i_reg     <= '0;
                    acc_reg   <= '0;
                end
                if (is_STATE_2) begin
                    acc_reg <= acc_reg + ld_data;
                end
                if (is_STATE_3) begin
                    i_reg <= i_reg + TRIP_W'(1);
                end
                if (is_STATE_4) begin
                    result_reg       <= acc_reg;
                    result_valid_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_toy_loop_datapath.sv
// ---------------------------------------------------------------------------
// tb_toy_loop_datapath
// Bench for toy_loop_datapath. A small one-hot controller model and a memory
// model with configurable ack wait drive the DUT. Expected sums and load
// addresses are queued when a run is issued; monitors pop and compare them
// whenever the DUT presents a result or an accepted load.
// ---------------------------------------------------------------------------
module tb_toy_loop_datapath;

    localparam int DW = 32;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [TW-1:0] trip_count = '0;
    logic [4:0]    st = 5'b00000;
    logic          fsm_stall, BB_1_EXIT, mem_req, result_valid;
    logic          mem_ack = 1'b0;
    logic [TW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] result;
`ifdef TOY_DP_OVERFLOW_EN
    logic          acc_overflow;
`endif

    always #5 clk = ~clk;

    toy_loop_datapath #(
        .DATA_W (DW),
        .TRIP_W (TW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .trip_count   (trip_count),
        .is_STATE_0   (st[0]),
        .is_STATE_1   (st[1]),
        .is_STATE_2   (st[2]),
        .is_STATE_3   (st[3]),
        .is_STATE_4   (st[4]),
        .fsm_stall    (fsm_stall),
        .BB_1_EXIT    (BB_1_EXIT),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .result       (result),
        .result_valid (result_valid)
`ifdef TOY_DP_OVERFLOW_EN
        ,
        .acc_overflow (acc_overflow)
`endif
    );

    logic [DW-1:0] mem [256];
    int            delay = 0;
    int            wait_cnt = 0;
    int            checks = 0;
    int            failures = 0;
    int            valid_cnt = 0;
    int            s3_cnt = 0;
    int            stall_cnt = 0;
    logic [DW-1:0] res_q [$];
    int            addr_q [$];
    logic [DW-1:0] exp_res;
    int            exp_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Result monitor.
    always @(negedge clk) begin
        if (reset && result_valid) begin
            valid_cnt++;
            if (res_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL result_unexpected actual=0x%0h expected=none", result);
            end else begin
                exp_res = res_q.pop_front();
                $display("result txn: got=0x%0h exp=0x%0h", result, exp_res);
                check("result", {32'b0, result}, {32'b0, exp_res});
            end
        end
    end

    // Load-address monitor: one transaction per accepted request.
    always @(negedge clk) begin
        if (reset && mem_req && mem_ack) begin
            if (addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL load_unexpected actual=0x%0h expected=none", mem_addr);
            end else begin
                exp_addr = addr_q.pop_front();
                $display("load txn: addr=%0d exp=%0d", mem_addr, exp_addr);
                check("load_addr", {56'b0, mem_addr}, 64'(exp_addr));
            end
        end
    end

    // One clock of controller + memory model. Controller decisions use the
    // DUT's combinational outputs sampled mid-cycle; all inputs change #1
    // after the rising edge.
    task automatic step();
        logic [4:0] nx;
        @(negedge clk);
        if (st[1] && fsm_stall) stall_cnt++;
        if (st[3]) s3_cnt++;
        nx = st;
        if (st[0])      nx = start ? 5'b00010 : 5'b00001;
        else if (st[1]) nx = fsm_stall ? 5'b00010 : 5'b00100;
        else if (st[2]) nx = 5'b01000;
        else if (st[3]) nx = BB_1_EXIT ? 5'b10000 : 5'b00010;
        else if (st[4]) nx = 5'b00001;
        @(posedge clk);
        #1;
        st    = nx;
        start = 1'b0;
        // Ack arrives after 'delay' wait cycles of an outstanding request.
        if (mem_req) begin
            if (wait_cnt == delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
            end
            wait_cnt++;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            wait_cnt  = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fsm_stall"},    64'(fsm_stall),    64'd0);
        check({tag, "_exit"},         64'(BB_1_EXIT),    64'd0);
        check({tag, "_mem_req"},      64'(mem_req),      64'd0);
        check({tag, "_result"},       64'(result),       64'd0);
        check({tag, "_result_valid"}, 64'(result_valid), 64'd0);
`ifdef TOY_DP_OVERFLOW_EN
        check({tag, "_overflow"},     64'(acc_overflow), 64'd0);
`endif
    endtask

    // Launch one kernel run from STATE_0 and follow it back to STATE_0.
    task automatic run_loop(input string name, input int trip, input int dly,
                            input logic [DW-1:0] exp, input int iters);
        int v0;
        int n;
        delay = dly;
        res_q.push_back(exp);
        for (int a = 0; a < iters; a++) addr_q.push_back(a);
        v0        = valid_cnt;
        s3_cnt    = 0;
        stall_cnt = 0;
        trip_count = trip[TW-1:0];
        start      = 1'b1;
        step();
        n = 1;
        while (st != 5'b00001 && n < 5000) begin
            step();
            n++;
        end
        if (st != 5'b00001) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d cycles expected=return to STATE_0", name, n);
            st = 5'b00001;
        end
        // Result is visible in the STATE_0 cycle; let the monitor see it.
        step();
        $display("run %s: trip=%0d delay=%0d iterations=%0d stall_cycles=%0d",
                 name, trip, dly, s3_cnt, stall_cnt);
        check({name, "_iterations"},   64'(s3_cnt),           64'(iters));
        check({name, "_stall_cycles"}, 64'(stall_cnt),        64'(iters * (2 + dly)));
        check({name, "_valid_pulses"}, 64'(valid_cnt - v0),   64'd1);
        check({name, "_queues_drained"}, 64'(res_q.size() + addr_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        for (int a = 0; a < 256; a++) mem[a] = '0;

        // Reset held for a few edges with the controller idle.
        reset = 1'b0;
        st    = 5'b00000;
        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b1;
        st    = 5'b00001;
        step();

        // Trip 4, words 1..4, zero-wait ack: 1+2+3+4 = 10.
        mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
        run_loop("trip4", 4, 0, 32'd10, 4);

        // Trip 0 runs exactly one iteration at address 0.
        mem[0] = 32'h0000_0055;
        run_loop("trip0", 0, 0, 32'h0000_0055, 1);

        // Ack after 5 wait cycles: stall per iteration = 1 (LD_IDLE) + 6 (LD_REQ).
        mem[0] = 32'd10; mem[1] = 32'd20;
        run_loop("ack_wait5", 2, 5, 32'd30, 2);

        // Wrap: 0xFFFFFFFF + 0x2 = 0x1 modulo 2^32.
        mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h0000_0002;
        run_loop("wrap", 2, 0, 32'h0000_0001, 2);
`ifdef TOY_DP_OVERFLOW_EN
        check("overflow_set", 64'(acc_overflow), 64'd1);
`endif

        // Next accepted start clears the overflow flag; no carry this time.
        mem[0] = 32'd3;
        run_loop("trip1", 1, 0, 32'd3, 1);
`ifdef TOY_DP_OVERFLOW_EN
        check("overflow_cleared", 64'(acc_overflow), 64'd0);
`endif

        // Reset while the load request is outstanding; ack arrives afterwards.
        delay      = 100;
        trip_count = 8'd3;
        start      = 1'b1;
        step();
        n = 0;
        while (!mem_req && n < 10) begin
            step();
            n++;
        end
        check("midload_req_seen", 64'(mem_req), 64'd1);
        reset = 1'b0;
        st    = 5'b00000;
        step();
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        check_reset_outputs("midload_reset");
        step();
        check("late_ack_ignored_req",   64'(mem_req),   64'd0);
        check("late_ack_ignored_stall", 64'(fsm_stall), 64'd0);
        st = 5'b00001;
        step();

        // Fresh start after the abandoned load completes normally.
        mem[0] = 32'd7;
        run_loop("after_reset", 1, 0, 32'd7, 1);

        // Trip 255: i runs 0..254, exit on the 254 compare; sum 0..254 = 32385.
        for (int a = 0; a < 256; a++) mem[a] = DW'(a);
        run_loop("trip255", 255, 0, 32'd32385, 255);

        check("final_queues_empty", 64'(res_q.size() + addr_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
